delay_sched: RTL and testbench
==============================

// Module: delay_sched
// PURPOSE
//  Controller for the variable delay line: owns its delta_i input. Accepts single delay-change
//  requests (valid/ready) or runs a stepped sweep (start..stop, fixed dwell per step). After every
//  change, drives valid_o low until the line holds only samples taken at the new delay
//  (delta + PIPE_LAT cycles), so the feedback path never consumes stale data.
// PARAMETERS
//  DELAY_WIDTH  8   width of delay value (matches delay line)
//  DWELL_WIDTH  16  width of dwell counter
//  PIPE_LAT     1   fixed latency of delay line, added to every settle interval
//  SWEEP_STEP   1   sweep increment, must be >=1
// PORTS
//  clk_i          in   1            clock
//  rst_i          in   1            synchronous reset, active-high
//  req_delta_i    in   DELAY_WIDTH  requested delay
//  req_valid_i    in   1            request valid
//  req_ready_o    out  1            = (state==IDLE) & ~sweep_go_i  (combinational)
//  sweep_go_i     in   1            start-sweep pulse, sampled in IDLE only
//  sweep_abort_i  in   1            abort running sweep
//  sweep_start_i  in   DELAY_WIDTH  first sweep delay (sampled at go)
//  sweep_stop_i   in   DELAY_WIDTH  last sweep delay, inclusive (sampled at go)
//  dwell_i        in   DWELL_WIDTH  valid cycles per step (sampled at go, 0 treated as 1)
//  delta_o        out  DELAY_WIDTH  to delay line delta_i, registered
//  valid_o        out  1            delay line output trustworthy, registered
//  sweep_active_o out  1            high in sweep states
//  sweep_done_o   out  1            one-cycle pulse when sweep completes (not on abort)
// BEHAVIOUR
//  - Reset: delta_o=0, valid_o=0, sweep_active_o=0, sweep_done_o=0, state=SETTLE, cnt=PIPE_LAT.
//    Exit reset -> valid_o=1 after PIPE_LAT+1 cycles. Reset mid-operation aborts everything identically.
//  - States: IDLE, SLEW (macro only), SETTLE, DWELL. Flag sw marks sweep ownership.
//  - IDLE: valid_o=1. Handshake at cycle N (req_valid_i & req_ready_o):
//    req == delta_o -> no change, valid_o stays 1, state stays IDLE.
//    else -> N+1: delta_o=req, valid_o=0, SETTLE with cnt=req+PIPE_LAT (DELAY_WIDTH+1 bits, no wrap).
//  - SETTLE: cnt decrements; at cnt==0 -> valid_o=1 next cycle; goto DWELL if sw else IDLE.
//    Request of delta D at N => valid_o rises at N+2+D+PIPE_LAT-1 = N+D+PIPE_LAT+1.
//  - sweep_go_i in IDLE (wins over req_valid_i): latch start/stop/dwell.
//    start>stop -> sweep_done_o pulses at N+1, delta_o unchanged, stay IDLE.
//    else sw=1, load delta_o=start as a change (SETTLE; settle runs even if start==delta_o).
//  - DWELL: valid_o=1, count dwell cycles; on last: next = delta_o+SWEEP_STEP computed in
//    DELAY_WIDTH+1 bits; next>stop -> sweep_done_o pulse, sw=0, IDLE; else load next as change.
//  - sweep_abort_i: in DWELL -> IDLE next cycle, delta_o held, valid_o stays 1; in SETTLE/SLEW ->
//    sw cleared, current settle finishes, then IDLE. No sweep_done_o. Ignored when sw=0.
//  - sweep_go_i / req_valid_i outside IDLE: ignored (ready low).
// CONFIGURATION
//  DELAY_SCHED_SLEW_EN defined: every change passes through SLEW: delta_o moves +/-1 per cycle
//    toward target, valid_o=0 throughout; on reaching target enter SETTLE (cnt=target+PIPE_LAT).
//    Abort in SLEW stops at current delta_o and settles there.
//  Undefined: SLEW state absent; delta_o jumps to target in one cycle.
// TESTING
//  1 rst_i 1 cycle, PIPE_LAT=1 -> delta_o=0, valid_o=0 for 2 cycles then 1, req_ready_o=1.
//  2 IDLE, req 10 accepted at N -> delta_o=10 at N+1, valid_o=0 until rises at N+12; req 10 again -> no drop.
//  3 sweep start=2 stop=6 dwell=3 STEP=2 -> delta_o 2,4,6, each 3 valid cycles, done 1-cycle pulse, IDLE.
//  4 sweep start=250 stop=255 STEP=8 (W=8) -> only 250 visited, done, no wrap to 2.
//  5 abort during SETTLE of step 2 -> settle completes, IDLE, no done; go+req same cycle -> sweep wins.
//  6 SLEW_EN: delta 0 -> req 5 -> delta_o 1,2,3,4,5 consecutive, valid_o low, then 6-cycle settle.

Source files
------------

// File: rtl/delay_sched.sv
// delay_sched: controller for a variable delay line.
// Accepts single delay-change requests (valid/ready) or runs a stepped sweep
// from start to stop (inclusive) with a fixed dwell per step. After every
// change valid_o is held low until the line contains only samples taken at
// the new delay (delta + PIPE_LAT cycles).
//
// Optional feature: define DELAY_SCHED_SLEW_EN to make every change walk
// delta_o toward the target one step per cycle before settling.
//
// Ports:
//   clk_i, rst_i     clock, synchronous active-high reset
//   req_delta_i      requested delay
//   req_valid_i      request valid
//   req_ready_o      request ready (IDLE and no sweep_go_i), combinational
//   sweep_go_i       start-sweep pulse, sampled in IDLE only
//   sweep_abort_i    abort running sweep
//   sweep_start_i    first sweep delay (sampled at go)
//   sweep_stop_i     last sweep delay, inclusive (sampled at go)
//   dwell_i          valid cycles per step (sampled at go, 0 treated as 1)
//   delta_o          delay value to the delay line, registered
//   valid_o          delay line output trustworthy, registered
//   sweep_active_o   sweep owns the delay line
//   sweep_done_o     one-cycle pulse on sweep completion (not on abort)
module delay_sched #(
  parameter int unsigned DELAY_WIDTH = 8,
  parameter int unsigned DWELL_WIDTH = 16,
  parameter int unsigned PIPE_LAT    = 1,
  parameter int unsigned SWEEP_STEP  = 1
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [DELAY_WIDTH-1:0] req_delta_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  input  logic                   sweep_go_i,
  input  logic                   sweep_abort_i,
  input  logic [DELAY_WIDTH-1:0] sweep_start_i,
  input  logic [DELAY_WIDTH-1:0] sweep_stop_i,
  input  logic [DWELL_WIDTH-1:0] dwell_i,
  output logic [DELAY_WIDTH-1:0] delta_o,
  output logic                   valid_o,
  output logic                   sweep_active_o,
  output logic                   sweep_done_o
);

  localparam int unsigned CW = DELAY_WIDTH + 1;
  localparam logic [CW-1:0] PL   = CW'(PIPE_LAT);
  localparam logic [CW-1:0] STEP = CW'(SWEEP_STEP);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_DWELL
`ifdef DELAY_SCHED_SLEW_EN
    , S_SLEW
`endif
  } state_t;

  state_t                 r_state, w_state;
  logic [CW-1:0]          r_cnt, w_cnt;
  logic [DWELL_WIDTH-1:0] r_dcnt, w_dcnt;
  logic [DWELL_WIDTH-1:0] r_dwell, w_dwell;
  logic [DELAY_WIDTH-1:0] r_delta, w_delta;
  logic [DELAY_WIDTH-1:0] r_stop, w_stop;
  logic                   r_valid, w_valid;
  logic                   r_sw, w_sw;
  logic                   r_done, w_done;
  logic                   w_chg;
  logic [DELAY_WIDTH-1:0] w_tgt;
  logic [CW-1:0]          w_next;
`ifdef DELAY_SCHED_SLEW_EN
  logic [DELAY_WIDTH-1:0] r_tgt, w_tgt_r;

  function automatic logic [DELAY_WIDTH-1:0] f_step(input logic [DELAY_WIDTH-1:0] cur,
                                                    input logic [DELAY_WIDTH-1:0] tgt);
    if (tgt > cur) return cur + DELAY_WIDTH'(1);
    else           return cur - DELAY_WIDTH'(1);
  endfunction
`endif

  assign req_ready_o    = (r_state == S_IDLE) & ~sweep_go_i;
  assign delta_o        = r_delta;
  assign valid_o        = r_valid;
  assign sweep_active_o = r_sw;
  assign sweep_done_o   = r_done;

  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_dcnt  = r_dcnt;
    w_dwell = r_dwell;
    w_delta = r_delta;
    w_stop  = r_stop;
    w_valid = r_valid;
    w_sw    = r_sw;
    w_done  = 1'b0;
    w_chg   = 1'b0;
    w_tgt   = r_delta;
    w_next  = {1'b0, r_delta} + STEP;
`ifdef DELAY_SCHED_SLEW_EN
    w_tgt_r = r_tgt;
`endif
    case (r_state)
      S_IDLE: begin
        if (sweep_go_i) begin
          w_stop  = sweep_stop_i;
          w_dwell = (dwell_i == '0) ? DWELL_WIDTH'(1) : dwell_i;
          if (sweep_start_i > sweep_stop_i) begin
            w_done = 1'b1;
          end else begin
            w_sw  = 1'b1;
            w_chg = 1'b1;
            w_tgt = sweep_start_i;
          end
        end else if (req_valid_i && (req_delta_i != r_delta)) begin
          w_chg = 1'b1;
          w_tgt = req_delta_i;
        end
      end
      S_SETTLE: begin
        if (sweep_abort_i) w_sw = 1'b0;
        // Finishing on cnt==1 makes valid_o rise delta+PIPE_LAT cycles after
        // the cycle in which the new delta_o first appears.
        if (r_cnt <= CW'(1)) begin
          w_valid = 1'b1;
          w_dcnt  = r_dwell;
          w_state = w_sw ? S_DWELL : S_IDLE;
        end else begin
          w_cnt = r_cnt - CW'(1);
        end
      end
      S_DWELL: begin
        if (sweep_abort_i) begin
          w_sw    = 1'b0;
          w_state = S_IDLE;
        end else if (r_dcnt <= DWELL_WIDTH'(1)) begin
          // Next step computed one bit wider so a sweep near the top of the
          // range terminates instead of wrapping.
          if (w_next > {1'b0, r_stop}) begin
            w_done  = 1'b1;
            w_sw    = 1'b0;
            w_state = S_IDLE;
          end else begin
            w_chg = 1'b1;
            w_tgt = w_next[DELAY_WIDTH-1:0];
          end
        end else begin
          w_dcnt = r_dcnt - DWELL_WIDTH'(1);
        end
      end
`ifdef DELAY_SCHED_SLEW_EN
      S_SLEW: begin
        if (sweep_abort_i && r_sw) begin
          w_sw    = 1'b0;
          w_state = S_SETTLE;
          w_cnt   = {1'b0, r_delta} + PL;
        end else begin
          w_delta = f_step(r_delta, r_tgt);
          if (w_delta == r_tgt) begin
            w_state = S_SETTLE;
            w_cnt   = {1'b0, r_tgt} + PL;
          end
        end
      end
`endif
      default: w_state = S_IDLE;
    endcase

    if (w_chg) begin
      w_valid = 1'b0;
`ifdef DELAY_SCHED_SLEW_EN
      // The first slew step is taken on the accepting cycle itself.
      w_tgt_r = w_tgt;
      if (w_tgt == r_delta) begin
        w_state = S_SETTLE;
        w_cnt   = {1'b0, w_tgt} + PL;
      end else begin
        w_delta = f_step(r_delta, w_tgt);
        if (w_delta == w_tgt) begin
          w_state = S_SETTLE;
          w_cnt   = {1'b0, w_tgt} + PL;
        end else begin
          w_state = S_SLEW;
        end
      end
`else
      w_delta = w_tgt;
      w_state = S_SETTLE;
      w_cnt   = {1'b0, w_tgt} + PL;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_SETTLE;
      r_cnt   <= PL;
      r_dcnt  <= '0;
      r_dwell <= '0;
      r_delta <= '0;
      r_stop  <= '0;
      r_valid <= 1'b0;
      r_sw    <= 1'b0;
      r_done  <= 1'b0;
`ifdef DELAY_SCHED_SLEW_EN
      r_tgt   <= '0;
`endif
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_dcnt  <= w_dcnt;
      r_dwell <= w_dwell;
      r_delta <= w_delta;
      r_stop  <= w_stop;
      r_valid <= w_valid;
      r_sw    <= w_sw;
      r_done  <= w_done;
`ifdef DELAY_SCHED_SLEW_EN
      r_tgt   <= w_tgt_r;
`endif
    end
  end

endmodule

// File: tb/tb_delay_sched.sv
// Directed testbench for delay_sched. Two instances share all inputs:
// u_dut uses SWEEP_STEP=2, u_dut8 uses SWEEP_STEP=8 (used for the top-of-range sweep).
module tb_delay_sched;
  logic        clk = 1'b0;
  logic        rst, req_valid, go, abort;
  logic [7:0]  req_delta, s_start, s_stop;
  logic [15:0] dwell;
  logic        ready, valid, active, done;
  logic [7:0]  delta;
  logic        ready8, valid8, active8, done8;
  logic [7:0]  delta8;
  int          n_checks = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  delay_sched #(.DELAY_WIDTH(8), .DWELL_WIDTH(16), .PIPE_LAT(1), .SWEEP_STEP(2)) u_dut (
    .clk_i(clk), .rst_i(rst), .req_delta_i(req_delta), .req_valid_i(req_valid),
    .req_ready_o(ready), .sweep_go_i(go), .sweep_abort_i(abort),
    .sweep_start_i(s_start), .sweep_stop_i(s_stop), .dwell_i(dwell),
    .delta_o(delta), .valid_o(valid), .sweep_active_o(active), .sweep_done_o(done));

  delay_sched #(.DELAY_WIDTH(8), .DWELL_WIDTH(16), .PIPE_LAT(1), .SWEEP_STEP(8)) u_dut8 (
    .clk_i(clk), .rst_i(rst), .req_delta_i(req_delta), .req_valid_i(req_valid),
    .req_ready_o(ready8), .sweep_go_i(go), .sweep_abort_i(abort),
    .sweep_start_i(s_start), .sweep_stop_i(s_stop), .dwell_i(dwell),
    .delta_o(delta8), .valid_o(valid8), .sweep_active_o(active8), .sweep_done_o(done8));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Ticks until the selected instance shows valid high; n = ticks taken, -1 on timeout.
  task automatic wait_rise(input bit use8, output int n);
    n = 0;
    while ((use8 ? valid8 : valid) !== 1'b1) begin
      if (n >= 3000) begin
        n = -1;
        return;
      end
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    n_checks++; if (delta !== 8'd0) begin n_fail++; $display("FAIL rst_delta: got %0d expected 0", delta); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %0b expected 0", valid); end
    n_checks++; if (active !== 1'b0) begin n_fail++; $display("FAIL rst_active: got %0b expected 0", active); end
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %0b expected 0", done); end
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %0b expected 0", ready); end
    rst = 1'b0;
    tick();
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL rst_valid_rise: got %0b expected 1", valid); end
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready_idle: got %0b expected 1", ready); end
  endtask

  task automatic test_request();
    int n, exp_n;
    logic [7:0] exp_first;
`ifdef DELAY_SCHED_SLEW_EN
    exp_first = 8'd1; exp_n = 20;
`else
    exp_first = 8'd10; exp_n = 11;
`endif
    req_delta = 8'd10; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    n_checks++; if (delta !== exp_first) begin n_fail++; $display("FAIL req_delta_first: got %0d expected %0d", delta, exp_first); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL req_valid_drop: got %0b expected 0", valid); end
    wait_rise(1'b0, n);
    n_checks++; if (n != exp_n) begin n_fail++; $display("FAIL req_settle_len: got %0d expected %0d", n, exp_n); end
    n_checks++; if (delta !== 8'd10) begin n_fail++; $display("FAIL req_delta: got %0d expected 10", delta); end
    req_valid = 1'b1;
    #1;
    n_checks++; if (ready !== 1'b1) begin n_fail++; $display("FAIL req_ready: got %0b expected 1", ready); end
    tick();
    req_valid = 1'b0;
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL req_same_nodrop: got %0b expected 1", valid); end
    tick();
    n_checks++; if (valid !== 1'b1 || delta !== 8'd10) begin n_fail++; $display("FAIL req_same_hold: got valid=%0b delta=%0d expected valid=1 delta=10", valid, delta); end
  endtask

  task automatic test_sweep();
    int n, k;
    s_start = 8'd2; s_stop = 8'd6; dwell = 16'd3; go = 1'b1;
    tick();
    go = 1'b0;
    n_checks++; if (active !== 1'b1 || valid !== 1'b0) begin n_fail++; $display("FAIL sweep_start: got active=%0b valid=%0b expected active=1 valid=0", active, valid); end
    for (int s = 0; s < 3; s++) begin
      wait_rise(1'b0, n);
      n_checks++; if (n < 0) begin n_fail++; $display("FAIL sweep_rise_timeout: got %0d expected >=0", n); end
      n_checks++; if (delta !== 8'(2 + 2 * s)) begin n_fail++; $display("FAIL sweep_step_delta: got %0d expected %0d", delta, 2 + 2 * s); end
      k = 1;
      for (int t = 0; t < 20; t++) begin
        tick();
        if (valid !== 1'b1 || done === 1'b1) break;
        k++;
      end
      n_checks++; if (k != 3) begin n_fail++; $display("FAIL sweep_dwell_len: got %0d expected 3", k); end
    end
    n_checks++; if (done !== 1'b1 || active !== 1'b0 || delta !== 8'd6 || valid !== 1'b1) begin
      n_fail++; $display("FAIL sweep_done: got done=%0b active=%0b delta=%0d valid=%0b expected 1 0 6 1", done, active, delta, valid); end
    tick();
    n_checks++; if (done !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL sweep_done_pulse: got done=%0b ready=%0b expected done=0 ready=1", done, ready); end
  endtask

  task automatic test_wrap();
    int n;
    s_start = 8'd250; s_stop = 8'd255; dwell = 16'd1; go = 1'b1;
    tick();
    go = 1'b0;
    n_checks++; if (active8 !== 1'b1) begin n_fail++; $display("FAIL wrap_active: got %0b expected 1", active8); end
    wait_rise(1'b1, n);
    n_checks++; if (n < 0) begin n_fail++; $display("FAIL wrap_rise_timeout: got %0d expected >=0", n); end
    n_checks++; if (delta8 !== 8'd250) begin n_fail++; $display("FAIL wrap_delta: got %0d expected 250", delta8); end
    tick();
    n_checks++; if (done8 !== 1'b1 || delta8 !== 8'd250 || active8 !== 1'b0) begin
      n_fail++; $display("FAIL wrap_done: got done=%0b delta=%0d active=%0b expected 1 250 0", done8, delta8, active8); end
    tick();
    n_checks++; if (done8 !== 1'b0 || delta8 !== 8'd250) begin n_fail++; $display("FAIL wrap_nowrap: got done=%0b delta=%0d expected 0 250", done8, delta8); end
    n = 0;
    while (active === 1'b1 && n < 3000) begin tick(); n++; end
    n_checks++; if (active !== 1'b0 || delta !== 8'd254) begin n_fail++; $display("FAIL wrap_step2_end: got active=%0b delta=%0d expected 0 254", active, delta); end
  endtask

  task automatic test_abort_settle();
    int n;
    s_start = 8'd2; s_stop = 8'd6; dwell = 16'd2; go = 1'b1;
    tick();
    go = 1'b0;
    wait_rise(1'b0, n);
    n = 0;
    while (!(delta === 8'd4 && valid === 1'b0) && n < 3000) begin tick(); n++; end
    n_checks++; if (delta !== 8'd4 || valid !== 1'b0) begin n_fail++; $display("FAIL abort_reach_step2: got delta=%0d valid=%0b expected 4 0", delta, valid); end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (active !== 1'b0 || valid !== 1'b0 || delta !== 8'd4) begin
      n_fail++; $display("FAIL abort_settle_state: got active=%0b valid=%0b delta=%0d expected 0 0 4", active, valid, delta); end
    wait_rise(1'b0, n);
    n_checks++; if (n != 4) begin n_fail++; $display("FAIL abort_settle_len: got %0d expected 4", n); end
    for (int t = 0; t < 3; t++) begin
      n_checks++; if (done !== 1'b0 || delta !== 8'd4 || valid !== 1'b1 || ready !== 1'b1) begin
        n_fail++; $display("FAIL abort_idle: got done=%0b delta=%0d valid=%0b ready=%0b expected 0 4 1 1", done, delta, valid, ready); end
      tick();
    end
  endtask

  task automatic test_abort_dwell();
    int n;
    s_start = 8'd20; s_stop = 8'd30; dwell = 16'd5; go = 1'b1;
    tick();
    go = 1'b0;
    wait_rise(1'b0, n);
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n_checks++; if (active !== 1'b0 || valid !== 1'b1 || delta !== 8'd20 || done !== 1'b0 || ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_dwell: got active=%0b valid=%0b delta=%0d done=%0b ready=%0b expected 0 1 20 0 1", active, valid, delta, done, ready); end
    tick();
    n_checks++; if (valid !== 1'b1 || delta !== 8'd20) begin n_fail++; $display("FAIL abort_dwell_hold: got valid=%0b delta=%0d expected 1 20", valid, delta); end
  endtask

  task automatic test_go_wins();
    int n;
    s_start = 8'd7; s_stop = 8'd7; dwell = 16'd0; go = 1'b1;
    req_delta = 8'd40; req_valid = 1'b1;
    #1;
    n_checks++; if (ready !== 1'b0) begin n_fail++; $display("FAIL gowin_ready: got %0b expected 0", ready); end
    tick();
    go = 1'b0; req_valid = 1'b0;
    n_checks++; if (active !== 1'b1 || valid !== 1'b0) begin n_fail++; $display("FAIL gowin_start: got active=%0b valid=%0b expected 1 0", active, valid); end
    wait_rise(1'b0, n);
    n_checks++; if (delta !== 8'd7) begin n_fail++; $display("FAIL gowin_delta: got %0d expected 7", delta); end
    tick();
    n_checks++; if (done !== 1'b1 || active !== 1'b0 || delta !== 8'd7) begin
      n_fail++; $display("FAIL gowin_dwell0_done: got done=%0b active=%0b delta=%0d expected 1 0 7", done, active, delta); end
  endtask

  task automatic test_empty_sweep();
    tick();
    s_start = 8'd9; s_stop = 8'd3; dwell = 16'd2; go = 1'b1;
    tick();
    go = 1'b0;
    n_checks++; if (done !== 1'b1 || delta !== 8'd7 || valid !== 1'b1 || active !== 1'b0) begin
      n_fail++; $display("FAIL empty_sweep: got done=%0b delta=%0d valid=%0b active=%0b expected 1 7 1 0", done, delta, valid, active); end
    tick();
    n_checks++; if (done !== 1'b0 || ready !== 1'b1) begin n_fail++; $display("FAIL empty_sweep_pulse: got done=%0b ready=%0b expected 0 1", done, ready); end
  endtask

  task automatic test_reset_mid();
    req_delta = 8'd100; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_checks++; if (delta !== 8'd0 || valid !== 1'b0 || active !== 1'b0 || done !== 1'b0) begin
      n_fail++; $display("FAIL rstmid: got delta=%0d valid=%0b active=%0b done=%0b expected 0 0 0 0", delta, valid, active, done); end
    tick();
    n_checks++; if (valid !== 1'b1 || ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_rise: got valid=%0b ready=%0b expected 1 1", valid, ready); end
  endtask

  task automatic test_small_change();
    int n;
    req_delta = 8'd5; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
`ifdef DELAY_SCHED_SLEW_EN
    for (int i = 1; i <= 5; i++) begin
      n_checks++; if (delta !== 8'(i) || valid !== 1'b0) begin
        n_fail++; $display("FAIL slew_step: got delta=%0d valid=%0b expected %0d 0", delta, valid, i); end
      if (i < 5) tick();
    end
`else
    n_checks++; if (delta !== 8'd5 || valid !== 1'b0) begin n_fail++; $display("FAIL jump_step: got delta=%0d valid=%0b expected 5 0", delta, valid); end
`endif
    wait_rise(1'b0, n);
    n_checks++; if (n != 6) begin n_fail++; $display("FAIL small_settle_len: got %0d expected 6", n); end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; req_valid = 1'b0; go = 1'b0; abort = 1'b0;
    req_delta = '0; s_start = '0; s_stop = '0; dwell = '0;
    test_reset();
    test_request();
    test_sweep();
    test_wrap();
    test_abort_settle();
    test_abort_dwell();
    test_go_wins();
    test_empty_sweep();
    test_reset_mid();
    test_small_change();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
